// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the ID/EX hazard control block
package hazard_pkg;

    // Register-index width of the MIPS-style rs/rt fields.
    localparam int REG_W = 5;

    // Register $zero: writes to it are discarded, so it never creates a hazard.
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Width of the internal stall/flush down-counter (parameters are 1..7).
    localparam int DCNT_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LSTALL   = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, clears count
//   inc    - count one event this cycle
//   count  - number of events since reset, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// rtl/id_ex_hazard_ctrl.sv - load-use stall, redirect flush and memory-wait control
//
// Ports:
//   clock, reset              - clock and synchronous active-high reset
//   id_rs, id_rt, id_uses_rt  - source fields of the instruction in decode
//   ex_memread, ex_rt         - load indication and destination from the ID/EX latch
//   ex_branch_taken, ex_jump  - redirect requests resolved in EX
//   mem_busy                  - data memory not ready, freezes everything
//   pc_write, ifid_write, idex_write - latch load enables
//   ifid_flush, idex_flush    - nop / bubble insertion
//   stall_count, flush_count  - saturating statistics
//   state                     - current FSM state for debug
module id_ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    state_e              state_q, state_d;
    state_e              saved_q, saved_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [DCNT_W-1:0]   saved_cnt_q, saved_cnt_d;

    // MEM_WAIT replays the interrupted state once memory is ready, so the
    // per-state logic below always works on this effective view.
    state_e              eff_state;
    logic [DCNT_W-1:0]   eff_cnt;

    logic hz, redirect, stall_inc, flush_inc;

    assign hz = ex_memread && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign redirect = ex_branch_taken || ex_jump;

    assign eff_state = (state_q == MEM_WAIT) ? saved_q     : state_q;
    assign eff_cnt   = (state_q == MEM_WAIT) ? saved_cnt_q : dcnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            dcnt_q      <= '0;
            saved_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            dcnt_q      <= dcnt_d;
            saved_cnt_q <= saved_cnt_d;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        saved_d     = saved_q;
        saved_cnt_d = saved_cnt_q;

        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_d    = MEM_WAIT;
            // Only capture on entry; a longer wait must keep the original context.
            if (state_q != MEM_WAIT) begin
                saved_d     = state_q;
                saved_cnt_d = dcnt_q;
            end
        end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                dcnt_d  = DCNT_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = RUN;
                dcnt_d  = '0;
            end
        end else begin
            case (eff_state)
                LSTALL: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    if (eff_cnt <= DCNT_W'(1)) begin
                        state_d = RUN;
                        dcnt_d  = '0;
                    end else begin
                        state_d = LSTALL;
                        dcnt_d  = eff_cnt - 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    if (eff_cnt <= DCNT_W'(1)) begin
                        state_d = RUN;
                        dcnt_d  = '0;
                    end else begin
                        state_d = FLUSH;
                        dcnt_d  = eff_cnt - 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    dcnt_d  = '0;
                    if (hz) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_d = LSTALL;
                            dcnt_d  = DCNT_W'(LOAD_USE_STALL - 1);
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign state = state_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb/tb_id_ex_hazard_ctrl.sv - directed self-checking bench for id_ex_hazard_ctrl
module tb_id_ex_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, ex_branch_taken, ex_jump, mem_busy;

    // dut_a: default parameters. dut_b: multi-cycle stall/flush, 4-bit counters.
    logic        a_pc_write, a_ifid_write, a_idex_write, a_ifid_flush, a_idex_flush;
    logic [15:0] a_stall_count, a_flush_count;
    logic [1:0]  a_state;
    logic        b_pc_write, b_ifid_write, b_idex_write, b_ifid_flush, b_idex_flush;
    logic [3:0]  b_stall_count, b_flush_count;
    logic [1:0]  b_state;

    logic [4:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_pc_write, a_ifid_write, a_idex_write, a_ifid_flush, a_idex_flush};
    assign b_ctrl = {b_pc_write, b_ifid_write, b_idex_write, b_ifid_flush, b_idex_flush};

    localparam logic [4:0] C_RESET = 5'b00011;
    localparam logic [4:0] C_IDLE  = 5'b11100;
    localparam logic [4:0] C_STALL = 5'b00101;
    localparam logic [4:0] C_REDIR = 5'b11111;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_FROZE = 5'b00000;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    id_ex_hazard_ctrl dut_a (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_busy(mem_busy),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .idex_write(a_idex_write),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .stall_count(a_stall_count), .flush_count(a_flush_count), .state(a_state)
    );

    id_ex_hazard_ctrl #(.LOAD_USE_STALL(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_busy(mem_busy),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .idex_write(b_idex_write),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .stall_count(b_stall_count), .flush_count(b_flush_count), .state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] r);
        ex_memread = 1'b1; ex_rt = r; id_rs = r;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        check("a reset ctrl", 32'(a_ctrl), 32'(C_RESET));
        check("b reset ctrl", 32'(b_ctrl), 32'(C_RESET));
        cyc();
        reset = 1'b0;
        #1;
        check("a post-reset state", 32'(a_state), 0);
        check("b post-reset state", 32'(b_state), 0);
        check("a post-reset stall", 32'(a_stall_count), 0);
        check("b post-reset flush", 32'(b_flush_count), 0);
        check("a idle ctrl", 32'(a_ctrl), 32'(C_IDLE));

        // Load-use on rs
        load_use(5'd8);
        #1;
        check("a lu ctrl", 32'(a_ctrl), 32'(C_STALL));
        check("b lu ctrl", 32'(b_ctrl), 32'(C_STALL));
        cyc();
        idle();
        #1;
        check("a lu release ctrl", 32'(a_ctrl), 32'(C_IDLE));
        check("a lu stall cnt", 32'(a_stall_count), 1);
        check("b lstall state", 32'(b_state), 1);
        check("b lstall ctrl", 32'(b_ctrl), 32'(C_STALL));
        cyc();
        check("b lstall done ctrl", 32'(b_ctrl), 32'(C_IDLE));
        check("b lu stall cnt", 32'(b_stall_count), 2);

        // $zero never stalls; rt only matters when it is a source
        load_use(5'd0);
        #1;
        check("a zero no stall", 32'(a_ctrl), 32'(C_IDLE));
        ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        check("b rt unused no stall", 32'(b_ctrl), 32'(C_IDLE));
        id_uses_rt = 1'b1;
        #1;
        check("a rt used stall", 32'(a_ctrl), 32'(C_STALL));
        cyc();
        idle();
        cyc();
        check("a stall cnt after rt", 32'(a_stall_count), 2);
        check("b stall cnt after rt", 32'(b_stall_count), 4);

        // Taken branch
        ex_branch_taken = 1'b1;
        #1;
        check("a redirect ctrl", 32'(a_ctrl), 32'(C_REDIR));
        check("b redirect ctrl", 32'(b_ctrl), 32'(C_REDIR));
        cyc();
        idle();
        #1;
        check("a after redirect ctrl", 32'(a_ctrl), 32'(C_IDLE));
        check("b flush state", 32'(b_state), 2);
        check("b flush ctrl", 32'(b_ctrl), 32'(C_FLUSH));
        check("a flush cnt", 32'(a_flush_count), 1);
        cyc();
        check("b flush done ctrl", 32'(b_ctrl), 32'(C_IDLE));
        check("b flush done state", 32'(b_state), 0);

        // Jump with a simultaneous hazard: redirect wins
        ex_jump = 1'b1;
        load_use(5'd8);
        #1;
        check("b jump+hz ctrl", 32'(b_ctrl), 32'(C_REDIR));
        cyc();
        idle();
        cyc();
        check("a jump+hz flush cnt", 32'(a_flush_count), 2);
        check("a jump+hz stall cnt", 32'(a_stall_count), 2);
        check("b jump+hz stall cnt", 32'(b_stall_count), 4);
        check("b jump+hz state", 32'(b_state), 0);

        // Memory wait in the middle of a multi-cycle stall
        load_use(5'd12);
        cyc();
        idle();
        mem_busy = 1'b1;
        #1;
        check("b busy ctrl 0", 32'(b_ctrl), 32'(C_FROZE));
        check("a busy ctrl 0", 32'(a_ctrl), 32'(C_FROZE));
        for (int i = 1; i < 3; i++) begin
            cyc();
            check($sformatf("b busy ctrl %0d", i), 32'(b_ctrl), 32'(C_FROZE));
            check($sformatf("b busy state %0d", i), 32'(b_state), 3);
        end
        cyc();
        mem_busy = 1'b0;
        #1;
        check("b resume ctrl", 32'(b_ctrl), 32'(C_STALL));
        check("a resume ctrl", 32'(a_ctrl), 32'(C_IDLE));
        check("b stall held in wait", 32'(b_stall_count), 5);
        cyc();
        check("b stall after resume", 32'(b_stall_count), 6);
        check("b state after resume", 32'(b_state), 0);
        check("a stall after wait", 32'(a_stall_count), 3);

        // Saturation of the 4-bit counter
        load_use(5'd4);
        for (int i = 0; i < 20; i++) cyc();
        idle();
        #1;
        check("b stall saturated", 32'(b_stall_count), 15);
        check("a stall 20 more", 32'(a_stall_count), 23);

        // Reset in the middle of a flush
        ex_branch_taken = 1'b1;
        cyc();
        idle();
        reset = 1'b1;
        #1;
        check("b mid-flush state", 32'(b_state), 2);
        check("b reset mid-flush ctrl", 32'(b_ctrl), 32'(C_RESET));
        cyc();
        reset = 1'b0;
        #1;
        check("b state after reset", 32'(b_state), 0);
        check("b stall after reset", 32'(b_stall_count), 0);
        check("b flush after reset", 32'(b_flush_count), 0);
        check("a flush after reset", 32'(a_flush_count), 0);
        check("b ctrl after reset", 32'(b_ctrl), 32'(C_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
